// File: rtl/alu_pkg.sv
// Shared ALU opcodes and default widths for the issue stage and its operand muxes.
package alu_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_PERF_W = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_MUL = 4'b0110,
    ALU_XOR = 4'b0111,
    ALU_SLT = 4'b1000
  } alu_op_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: EX/MEM forward, then MEM/WB forward, then regfile; x0 is always zero.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_srcAddr,
  input  logic [XLEN-1:0]   i_rfData,
  input  logic              i_exmWrite,
  input  logic [REG_AW-1:0] i_exmAddr,
  input  logic [XLEN-1:0]   i_exmData,
  input  logic              i_mwbWrite,
  input  logic [REG_AW-1:0] i_mwbAddr,
  input  logic [XLEN-1:0]   i_mwbData,
  output logic [XLEN-1:0]   o_operand
);

  logic w_srcZero;

  assign w_srcZero = (i_srcAddr == '0);

  always_comb begin
    o_operand = i_rfData;
    if (w_srcZero) begin
      o_operand = '0;
    end else if (i_exmWrite && (i_exmAddr == i_srcAddr)) begin
      o_operand = i_exmData;
    end else if (i_mwbWrite && (i_mwbAddr == i_srcAddr)) begin
      o_operand = i_mwbData;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX register feeding the ALU: forwarding, imm select, load-use stall, flush, valid/ready.
// Define ALU_ISSUE_PERF_EN to add the stall_cnt load-use stall counter.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
`ifdef ALU_ISSUE_PERF_EN
  , parameter int PERF_W = DEF_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic              dec_use_imm,
  input  logic [3:0]        dec_alu_op,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic              dec_reg_write,
  input  logic              exm_reg_write,
  input  logic              exm_is_load,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_reg1,
  output logic [XLEN-1:0]   ex_reg2,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write
`ifdef ALU_ISSUE_PERF_EN
  , output logic [PERF_W-1:0] stall_cnt
`endif
);

  logic              r_exValid;
  logic [XLEN-1:0]   r_exReg1;
  logic [XLEN-1:0]   r_exReg2;
  logic [3:0]        r_exAluOp;
  logic [REG_AW-1:0] r_exRdAddr;
  logic              r_exRegWrite;

  logic              w_luse;
  logic              w_capture;
  logic [XLEN-1:0]   w_rs1Fwd;
  logic [XLEN-1:0]   w_rs2Fwd;

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs1Mux (
    .i_srcAddr (dec_rs1_addr),
    .i_rfData  (dec_rs1_data),
    .i_exmWrite(exm_reg_write),
    .i_exmAddr (exm_rd_addr),
    .i_exmData (exm_result),
    .i_mwbWrite(mwb_reg_write),
    .i_mwbAddr (mwb_rd_addr),
    .i_mwbData (mwb_result),
    .o_operand (w_rs1Fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs2Mux (
    .i_srcAddr (dec_rs2_addr),
    .i_rfData  (dec_rs2_data),
    .i_exmWrite(exm_reg_write),
    .i_exmAddr (exm_rd_addr),
    .i_exmData (exm_result),
    .i_mwbWrite(mwb_reg_write),
    .i_mwbAddr (mwb_rd_addr),
    .i_mwbData (mwb_result),
    .o_operand (w_rs2Fwd)
  );

  // A load in EX/MEM has no data yet, so a dependent instruction must wait a cycle.
  assign w_luse = exm_is_load & exm_reg_write & (exm_rd_addr != '0) & dec_valid &
                  ((exm_rd_addr == dec_rs1_addr) |
                   ((exm_rd_addr == dec_rs2_addr) & ~dec_use_imm));

  assign dec_ready = (~r_exValid | ex_ready) & ~w_luse & ~flush;
  assign w_capture = dec_valid & dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid    <= 1'b0;
      r_exReg1     <= '0;
      r_exReg2     <= '0;
      r_exAluOp    <= '0;
      r_exRdAddr   <= '0;
      r_exRegWrite <= 1'b0;
    end else if (flush) begin
      r_exValid <= 1'b0;
    end else if (w_capture) begin
      r_exValid    <= 1'b1;
      r_exReg1     <= w_rs1Fwd;
      r_exReg2     <= dec_use_imm ? dec_imm : w_rs2Fwd;
      r_exAluOp    <= dec_alu_op;
      r_exRdAddr   <= dec_rd_addr;
      r_exRegWrite <= dec_reg_write;
    end else if (ex_ready) begin
      r_exValid <= 1'b0;
    end
  end

  assign ex_valid     = r_exValid;
  assign ex_reg1      = r_exReg1;
  assign ex_reg2      = r_exReg2;
  assign ex_alu_op    = r_exAluOp;
  assign ex_rd_addr   = r_exRdAddr;
  assign ex_reg_write = r_exRegWrite;

`ifdef ALU_ISSUE_PERF_EN
  logic [PERF_W-1:0] r_stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (w_luse && !flush) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign stall_cnt = r_stallCnt;
`else
  // Without the perf option there is no stall counter.
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; stall_cnt is checked when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1_addr;
  logic [4:0]  dec_rs2_addr;
  logic [31:0] dec_rs1_data;
  logic [31:0] dec_rs2_data;
  logic [31:0] dec_imm;
  logic        dec_use_imm;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_rd_addr;
  logic        dec_reg_write;
  logic        exm_reg_write;
  logic        exm_is_load;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_result;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cnt;
  int unsigned expStall;
`endif

  int checks;
  int failures;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rs1_data (dec_rs1_data),
    .dec_rs2_data (dec_rs2_data),
    .dec_imm      (dec_imm),
    .dec_use_imm  (dec_use_imm),
    .dec_alu_op   (dec_alu_op),
    .dec_rd_addr  (dec_rd_addr),
    .dec_reg_write(dec_reg_write),
    .exm_reg_write(exm_reg_write),
    .exm_is_load  (exm_is_load),
    .exm_rd_addr  (exm_rd_addr),
    .exm_result   (exm_result),
    .mwb_reg_write(mwb_reg_write),
    .mwb_rd_addr  (mwb_rd_addr),
    .mwb_result   (mwb_result),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_reg1      (ex_reg1),
    .ex_reg2      (ex_reg2),
    .ex_alu_op    (ex_alu_op),
    .ex_rd_addr   (ex_rd_addr),
    .ex_reg_write (ex_reg_write)
`ifdef ALU_ISSUE_PERF_EN
    , .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush         = 1'b0;
    dec_valid     = 1'b0;
    dec_rs1_addr  = '0;
    dec_rs2_addr  = '0;
    dec_rs1_data  = '0;
    dec_rs2_data  = '0;
    dec_imm       = '0;
    dec_use_imm   = 1'b0;
    dec_alu_op    = '0;
    dec_rd_addr   = '0;
    dec_reg_write = 1'b0;
    exm_reg_write = 1'b0;
    exm_is_load   = 1'b0;
    exm_rd_addr   = '0;
    exm_result    = '0;
    mwb_reg_write = 1'b0;
    mwb_rd_addr   = '0;
    mwb_result    = '0;
    ex_ready      = 1'b1;
  endtask

  // Present a register-register instruction on the decode side.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [31:0] d1,
                               input logic [4:0] rs2, input logic [31:0] d2,
                               input logic [3:0] op, input logic [4:0] rd);
    dec_valid     = 1'b1;
    dec_rs1_addr  = rs1;
    dec_rs1_data  = d1;
    dec_rs2_addr  = rs2;
    dec_rs2_data  = d2;
    dec_alu_op    = op;
    dec_rd_addr   = rd;
    dec_reg_write = 1'b1;
    dec_use_imm   = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(5'd1, 32'h11, 5'd2, 32'h22, ALU_ADD, 5'd4);
    step();
    checks++;
    if (ex_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pre_capture: ex_valid=%0b expected 1", ex_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_reg1, ex_reg2, ex_alu_op, ex_rd_addr, ex_reg_write} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_async_clear: v=%0b r1=%h r2=%h op=%h rd=%0d we=%0b expected all 0",
               ex_valid, ex_reg1, ex_reg2, ex_alu_op, ex_rd_addr, ex_reg_write);
    end
`ifdef ALU_ISSUE_PERF_EN
    expStall = 0;
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
    applyStimulus(5'd1, 32'h0000_0111, 5'd2, 32'h0000_0222, ALU_ADD, 5'd4);
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_op !== ALU_ADD || ex_reg1 !== 32'h111 ||
        ex_reg2 !== 32'h222 || ex_rd_addr !== 5'd4 || ex_reg_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_capture: v=%0b op=%h r1=%h r2=%h rd=%0d we=%0b expected 1 2 111 222 4 1",
               ex_valid, ex_alu_op, ex_reg1, ex_reg2, ex_rd_addr, ex_reg_write);
    end
  endtask

  task automatic test_forward();
    clearInputs();
    applyStimulus(5'd5, 32'h99, 5'd6, 32'h66, ALU_SUB, 5'd7);
    exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_result = 32'h10;
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd5; mwb_result = 32'h20;
    step();
    checks++;
    if (ex_reg1 !== 32'h10 || ex_reg2 !== 32'h66) begin
      failures++;
      $display("[TB] FAIL fwd_exm_priority: r1=%h r2=%h expected 10 66", ex_reg1, ex_reg2);
    end
    exm_reg_write = 1'b0;
    step();
    checks++;
    if (ex_reg1 !== 32'h20) begin
      failures++;
      $display("[TB] FAIL fwd_mwb: r1=%h expected 20", ex_reg1);
    end
    mwb_reg_write = 1'b0;
    exm_reg_write = 1'b1; exm_rd_addr = 5'd6; exm_result = 32'hABCD;
    step();
    checks++;
    if (ex_reg1 !== 32'h99 || ex_reg2 !== 32'hABCD || ex_alu_op !== ALU_SUB) begin
      failures++;
      $display("[TB] FAIL fwd_rs2_exm: r1=%h r2=%h op=%h expected 99 abcd 4", ex_reg1, ex_reg2, ex_alu_op);
    end
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd6; mwb_result = 32'h5A5A;
    step();
    checks++;
    if (ex_reg2 !== 32'h5A5A) begin
      failures++;
      $display("[TB] FAIL fwd_rs2_mwb: r2=%h expected 5a5a", ex_reg2);
    end
  endtask

  task automatic test_x0();
    clearInputs();
    applyStimulus(5'd0, 32'h7, 5'd0, 32'h9, ALU_XOR, 5'd8);
    exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 32'hFFFF_FFFF;
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd0; mwb_result = 32'hEEEE_EEEE;
    step();
    checks++;
    if (ex_reg1 !== 32'h0 || ex_reg2 !== 32'h0 || ex_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL x0_zero: r1=%h r2=%h v=%0b expected 0 0 1", ex_reg1, ex_reg2, ex_valid);
    end
  endtask

  task automatic test_load_use();
    clearInputs();
    applyStimulus(5'd1, 32'h1, 5'd3, 32'h33, ALU_OR, 5'd9);
    exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'hDEAD;
    #1;
    checks++;
    if (dec_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL luse_rs2_stall: dec_ready=%0b expected 0", dec_ready);
    end
    step();
`ifdef ALU_ISSUE_PERF_EN
    expStall++;
`endif
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL luse_bubble: ex_valid=%0b expected 0", ex_valid);
    end
    dec_use_imm = 1'b1;
    dec_imm     = 32'h0000_1234;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL luse_imm_ready: dec_ready=%0b expected 1", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_reg2 !== 32'h1234 || ex_reg1 !== 32'h1) begin
      failures++;
      $display("[TB] FAIL luse_imm_capture: v=%0b r1=%h r2=%h expected 1 1 1234", ex_valid, ex_reg1, ex_reg2);
    end
    dec_use_imm  = 1'b0;
    dec_rs1_addr = 5'd3;
    dec_rs2_addr = 5'd4;
    #1;
    checks++;
    if (dec_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL luse_rs1_stall: dec_ready=%0b expected 0", dec_ready);
    end
    dec_valid = 1'b0;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL luse_needs_valid: dec_ready=%0b expected 1", dec_ready);
    end
    step();
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if (stall_cnt !== expStall) begin
      failures++;
      $display("[TB] FAIL luse_stall_cnt: got %0d expected %0d", stall_cnt, expStall);
    end
`endif
  endtask

  task automatic test_back_to_back();
    clearInputs();
    applyStimulus(5'd10, 32'hAAAA, 5'd11, 32'hBBBB, ALU_AND, 5'd12);
    step();
    ex_ready = 1'b0;
    applyStimulus(5'd13, 32'hCCCC, 5'd14, 32'hDDDD, ALU_SLT, 5'd15);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dec_ready !== 1'b0 || ex_valid !== 1'b1 || ex_reg1 !== 32'hAAAA ||
          ex_reg2 !== 32'hBBBB || ex_alu_op !== ALU_AND || ex_rd_addr !== 5'd12) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d: rdy=%0b v=%0b r1=%h r2=%h op=%h rd=%0d expected 0 1 aaaa bbbb 0 12",
                 i, dec_ready, ex_valid, ex_reg1, ex_reg2, ex_alu_op, ex_rd_addr);
      end
      step();
    end
    ex_ready = 1'b1;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release_ready: dec_ready=%0b expected 1", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_reg1 !== 32'hCCCC || ex_reg2 !== 32'hDDDD || ex_alu_op !== ALU_SLT) begin
      failures++;
      $display("[TB] FAIL bp_next_capture: v=%0b r1=%h r2=%h op=%h expected 1 cccc dddd 8",
               ex_valid, ex_reg1, ex_reg2, ex_alu_op);
    end
  endtask

  task automatic test_flush();
    // ex_valid is 1 holding CCCC from the previous task; stall held so flush must beat it.
    ex_ready = 1'b0;
    applyStimulus(5'd9, 32'h1111, 5'd2, 32'h2222, ALU_MUL, 5'd3);
    exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd_addr = 5'd9;
    flush = 1'b1;
    #1;
    checks++;
    if (dec_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_ready: dec_ready=%0b expected 0", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg1 !== 32'hCCCC || ex_alu_op !== ALU_SLT) begin
      failures++;
      $display("[TB] FAIL flush_kill: v=%0b r1=%h op=%h expected 0 cccc 8", ex_valid, ex_reg1, ex_alu_op);
    end
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if (stall_cnt !== expStall) begin
      failures++;
      $display("[TB] FAIL flush_stall_cnt: got %0d expected %0d", stall_cnt, expStall);
    end
`endif
    clearInputs();
    ex_ready = 1'b0;
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_stays_empty: ex_valid=%0b expected 0", ex_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clearInputs();
    test_reset();
    test_forward();
    test_x0();
    test_load_use();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
